// File: rtl/exe_stage_pipe.sv
// ---------------------------------------------------------------------------
// exe_stage_pipe
//
// Execute stage of a simple in-order pipeline. It selects each operand and the
// store data from the local value or from the MEM/WB forwarding paths. It runs
// the ALU and registers the result together with the pass-through control
// into the EXE/MEM pipeline register.
//
// Optional feature macro: EXE_STAGE_MUL_EN
//   defined   : command 1100 (MUL) runs on an iterative shift-add multiplier.
//               It takes WIDTH cycles, and stall is high while it runs.
//   undefined : there is no multiplier and no FSM. 1100 yields 0 with
//               latency 1, and stall is tied to 0.
//
// Parameters
//   WIDTH        datapath width (power of two, 8..64)
//   REG_ADDR_W   destination-register tag width
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid                       instruction presented this cycle
//   exe_cmd                        4-bit operation code
//   val1_sel/val2_sel/st_val_sel   operand source select (0/3 local,
//                                  1 alu_res_mem, 2 result_wb)
//   val1, val2, st_value_in        local operands and store data
//   alu_res_mem, result_wb         forwarded values from MEM and WB
//   dest_in, wb_en_in,
//   mem_r_en_in, mem_w_en_in       pass-through control
//   stall                          stage busy (registered)
//   out_valid                      EXE/MEM register holds a valid instruction
//   alu_result, st_value_out,
//   dest_out, wb_en_out,
//   mem_r_en_out, mem_w_en_out     registered stage outputs
// ---------------------------------------------------------------------------
module exe_stage_pipe #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            exe_cmd,
  input  logic [1:0]            val1_sel,
  input  logic [1:0]            val2_sel,
  input  logic [1:0]            st_val_sel,
  input  logic [WIDTH-1:0]      val1,
  input  logic [WIDTH-1:0]      val2,
  input  logic [WIDTH-1:0]      st_value_in,
  input  logic [WIDTH-1:0]      alu_res_mem,
  input  logic [WIDTH-1:0]      result_wb,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  output logic                  stall,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      alu_result,
  output logic [WIDTH-1:0]      st_value_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  // Forwarding mux: codes 0 and 3 both pick the local value.
  function automatic logic [WIDTH-1:0] selOperand(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] localVal,
    input logic [WIDTH-1:0] memVal,
    input logic [WIDTH-1:0] wbVal
  );
    case (sel)
      2'd1:    return memVal;
      2'd2:    return wbVal;
      default: return localVal;
    endcase
  endfunction

  // Single-cycle ALU. MUL returns 0 here. When the multiplier is built, its
  // result comes from the iterative datapath instead.
  function automatic logic [WIDTH-1:0] aluCompute(
    input logic [3:0]       cmd,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0] shamt;
    shamt = b[SHW-1:0];
    case (cmd)
      CMD_ADD: return a + b;
      CMD_SUB: return a - b;
      CMD_AND: return a & b;
      CMD_OR:  return a | b;
      CMD_NOR: return ~(a | b);
      CMD_XOR: return a ^ b;
      CMD_SLL: return a << shamt;
      CMD_SRA: return WIDTH'($signed(a) >>> shamt);
      CMD_SRL: return a >> shamt;
      CMD_MUL: return '0;
      default: return '0;
    endcase
  endfunction

  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH-1:0] w_stData;
  logic [WIDTH-1:0] w_aluRes;
  logic             w_accept;
  logic             w_singleAccept;
  logic             w_mulDone;
  logic [WIDTH-1:0] w_mulResult;
  logic [WIDTH-1:0] w_doneSt;
  logic [REG_ADDR_W-1:0] w_doneDest;
  logic             w_doneWb;
  logic             w_doneMr;
  logic             w_doneMw;

  // Resolve the operands and store data from the current forwarding inputs.
  // These values matter only on the accept edge.
  always_comb begin
    w_opA    = selOperand(val1_sel, val1, alu_res_mem, result_wb);
    w_opB    = selOperand(val2_sel, val2, alu_res_mem, result_wb);
    w_stData = selOperand(st_val_sel, st_value_in, alu_res_mem, result_wb);
    w_aluRes = aluCompute(exe_cmd, w_opA, w_opB);
  end

  assign w_accept = in_valid & ~stall;

`ifdef EXE_STAGE_MUL_EN

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_stall;
  logic [SHW:0]     r_count;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0] r_pendSt;
  logic [REG_ADDR_W-1:0] r_pendDest;
  logic             r_pendWb;
  logic             r_pendMr;
  logic             r_pendMw;
  logic             w_mulStart;
  logic             w_lastStep;

  assign w_mulStart     = w_accept && (exe_cmd == CMD_MUL);
  assign w_singleAccept = w_accept && (exe_cmd != CMD_MUL);
  assign w_lastStep     = (r_count == (SHW + 1)'(1));
  assign w_mulDone      = (r_state == MUL_RUN) && w_lastStep;

  // State register. The stall flag is a separate flop that tracks the next
  // state, so stall never has a combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_stall <= (w_nextState == MUL_RUN);
    end
  end

  // Next-state logic. An accepted MUL enters MUL_RUN. The final multiplier
  // step (count == 1) returns to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_mulStart) w_nextState = MUL_RUN;
      MUL_RUN: if (w_lastStep) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign stall = r_stall;

  // Shift-add step. If the low multiplier bit is set, the shifted multiplicand
  // is added into the running partial product.
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Multiplier datapath. The accept edge captures the resolved operands and
  // the pass-through fields. Later forwarding inputs are never looked at again.
  // Each MUL_RUN edge then consumes one multiplier bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_pendSt   <= '0;
      r_pendDest <= '0;
      r_pendWb   <= 1'b0;
      r_pendMr   <= 1'b0;
      r_pendMw   <= 1'b0;
    end else if (w_mulStart) begin
      r_count    <= (SHW + 1)'(WIDTH);
      r_mcand    <= w_opA;
      r_mplier   <= w_opB;
      r_acc      <= '0;
      r_pendSt   <= w_stData;
      r_pendDest <= dest_in;
      r_pendWb   <= wb_en_in;
      r_pendMr   <= mem_r_en_in;
      r_pendMw   <= mem_w_en_in;
    end else if (r_state == MUL_RUN) begin
      r_count  <= r_count - (SHW + 1)'(1);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_accNext;
    end
  end

  assign w_mulResult = w_accNext;
  assign w_doneSt    = r_pendSt;
  assign w_doneDest  = r_pendDest;
  assign w_doneWb    = r_pendWb;
  assign w_doneMr    = r_pendMr;
  assign w_doneMw    = r_pendMw;

`else

  // No multiplier is built. Every command, 1100 included, finishes in one
  // cycle, and the stage never stalls.
  assign stall          = 1'b0;
  assign w_singleAccept = w_accept;
  assign w_mulDone      = 1'b0;
  assign w_mulResult    = '0;
  assign w_doneSt       = '0;
  assign w_doneDest     = '0;
  assign w_doneWb       = 1'b0;
  assign w_doneMr       = 1'b0;
  assign w_doneMw       = 1'b0;

`endif

  logic [WIDTH-1:0]      r_aluResult;
  logic [WIDTH-1:0]      r_stValue;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_outValid;
  logic                  r_wbEn;
  logic                  r_memREn;
  logic                  r_memWEn;

  // EXE/MEM register. The valid flag and the control flags default to a
  // bubble. The data fields hold unless a single-cycle instruction is accepted
  // or a multiply completes. While a multiply runs, MEM only sees bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluResult <= '0;
      r_stValue   <= '0;
      r_dest      <= '0;
      r_outValid  <= 1'b0;
      r_wbEn      <= 1'b0;
      r_memREn    <= 1'b0;
      r_memWEn    <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      r_wbEn     <= 1'b0;
      r_memREn   <= 1'b0;
      r_memWEn   <= 1'b0;
      if (w_mulDone) begin
        r_aluResult <= w_mulResult;
        r_stValue   <= w_doneSt;
        r_dest      <= w_doneDest;
        r_outValid  <= 1'b1;
        r_wbEn      <= w_doneWb;
        r_memREn    <= w_doneMr;
        r_memWEn    <= w_doneMw;
      end else if (w_singleAccept) begin
        r_aluResult <= w_aluRes;
        r_stValue   <= w_stData;
        r_dest      <= dest_in;
        r_outValid  <= 1'b1;
        r_wbEn      <= wb_en_in;
        r_memREn    <= mem_r_en_in;
        r_memWEn    <= mem_w_en_in;
      end
    end
  end

  assign alu_result   = r_aluResult;
  assign st_value_out = r_stValue;
  assign dest_out     = r_dest;
  assign out_valid    = r_outValid;
  assign wb_en_out    = r_wbEn;
  assign mem_r_en_out = r_memREn;
  assign mem_w_en_out = r_memWEn;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_exe_stage_pipe
//
// Testbench for exe_stage_pipe with WIDTH=32.
// The driver issues directed and random instructions. For each accepted
// instruction it pushes the expected EXE/MEM contents and the cycle on which
// they must appear into a queue. A monitor process pops and compares these
// entries whenever out_valid is high. On every other cycle it checks for a
// bubble with held data, and it checks stall against the model's busy window.
// ---------------------------------------------------------------------------
module tb_exe_stage_pipe;

  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [3:0]    exe_cmd;
  logic [1:0]    val1_sel, val2_sel, st_val_sel;
  logic [W-1:0]  val1, val2, st_value_in, alu_res_mem, result_wb;
  logic [RA-1:0] dest_in;
  logic          wb_en_in, mem_r_en_in, mem_w_en_in;
  logic          stall, out_valid;
  logic [W-1:0]  alu_result, st_value_out;
  logic [RA-1:0] dest_out;
  logic          wb_en_out, mem_r_en_out, mem_w_en_out;

  exe_stage_pipe #(.WIDTH(W), .REG_ADDR_W(RA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .exe_cmd(exe_cmd),
    .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
    .val1(val1), .val2(val2), .st_value_in(st_value_in),
    .alu_res_mem(alu_res_mem), .result_wb(result_wb),
    .dest_in(dest_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .stall(stall), .out_valid(out_valid),
    .alu_result(alu_result), .st_value_out(st_value_out), .dest_out(dest_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [W-1:0]  st;
    logic [RA-1:0] dest;
    logic          wb;
    logic          mr;
    logic          mw;
    int            due;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   busyUntil = 0;
  logic [W-1:0]  lastRes = '0;
  logic [W-1:0]  lastSt = '0;
  logic [RA-1:0] lastDest = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: the operand source chosen by the select code.
  function automatic logic [W-1:0] refPick(input logic [1:0] sel, input logic [W-1:0] loc,
                                           input logic [W-1:0] mem, input logic [W-1:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return loc;
  endfunction

  // Reference model: the arithmetic result of one command, modulo 2^32.
  function automatic logic [W-1:0] refAlu(input logic [3:0] cmd, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] prod;
    int          sh;
    sh = int'(b % 32);
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9:  return W'($signed(a) >>> sh);
      4'd10: return a >> sh;
`ifdef EXE_STAGE_MUL_EN
      4'd12: begin prod = {32'b0, a} * {32'b0, b}; return prod[W-1:0]; end
`else
      4'd12: begin prod = 64'd0; return prod[W-1:0]; end
`endif
      default: return '0;
    endcase
  endfunction

  // Wait for a cycle with stall low. Random junk with in_valid=1 is driven
  // meanwhile and must be ignored. The instruction is then presented, and its
  // expected outcome is pushed into the queue.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [1:0] s1, input logic [1:0] s2,
                               input logic [1:0] ss, input logic [W-1:0] v1, input logic [W-1:0] v2,
                               input logic [W-1:0] sv, input logic [W-1:0] mem, input logic [W-1:0] wb,
                               input logic [RA-1:0] dst, input logic [2:0] ctl);
    exp_t e;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (stall === 1'b1 && guard < 100) begin
      in_valid = 1'b1; exe_cmd = 4'($urandom); val1_sel = 2'($urandom); val2_sel = 2'($urandom);
      st_val_sel = 2'($urandom); val1 = $urandom; val2 = $urandom; st_value_in = $urandom;
      alu_res_mem = $urandom; result_wb = $urandom; dest_in = 5'($urandom);
      {wb_en_in, mem_r_en_in, mem_w_en_in} = 3'($urandom);
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("stallTimeout", 64'(stall), 64'd0);
    in_valid = 1'b1; exe_cmd = cmd; val1_sel = s1; val2_sel = s2; st_val_sel = ss;
    val1 = v1; val2 = v2; st_value_in = sv; alu_res_mem = mem; result_wb = wb; dest_in = dst;
    {wb_en_in, mem_r_en_in, mem_w_en_in} = ctl;
    e.res  = refAlu(cmd, refPick(s1, v1, mem, wb), refPick(s2, v2, mem, wb));
    e.st   = refPick(ss, sv, mem, wb);
    e.dest = dst;
    {e.wb, e.mr, e.mw} = ctl;
`ifdef EXE_STAGE_MUL_EN
    if (cmd == 4'd12) begin
      e.due = cyc + 1 + W;
      busyUntil = cyc + 1 + W;
    end else e.due = cyc + 1;
`else
    e.due = cyc + 1;
`endif
    sbQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; alu_res_mem = $urandom; result_wb = $urandom;
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (rst) begin
      checkOutput("rstOutValid", 64'(out_valid), 64'd0);
      checkOutput("rstStall", 64'(stall), 64'd0);
      checkOutput("rstAluResult", 64'(alu_result), 64'd0);
      checkOutput("rstStValue", 64'(st_value_out), 64'd0);
      checkOutput("rstCtl", 64'({dest_out, wb_en_out, mem_r_en_out, mem_w_en_out}), 64'd0);
      lastRes = '0; lastSt = '0; lastDest = '0;
    end else begin
      checkOutput("stall", 64'(stall), 64'(cyc < busyUntil));
      if (out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedValid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("latency", 64'(cyc), 64'(e.due));
          checkOutput("aluResult", 64'(alu_result), 64'(e.res));
          checkOutput("stValueOut", 64'(st_value_out), 64'(e.st));
          checkOutput("destOut", 64'(dest_out), 64'(e.dest));
          checkOutput("ctlOut", 64'({wb_en_out, mem_r_en_out, mem_w_en_out}),
                      64'({e.wb, e.mr, e.mw}));
        end
        lastRes = alu_result; lastSt = st_value_out; lastDest = dest_out;
      end else begin
        checkOutput("bubbleCtl", 64'({wb_en_out, mem_r_en_out, mem_w_en_out}), 64'd0);
        checkOutput("holdData", 64'({alu_result, st_value_out}), {lastRes, lastSt});
        checkOutput("holdDest", 64'(dest_out), 64'(lastDest));
        if (sbQ.size() > 0 && sbQ[0].due <= cyc)
          checkOutput("missingValid", 64'(out_valid), 64'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; exe_cmd = '0; val1_sel = '0; val2_sel = '0; st_val_sel = '0;
    val1 = '0; val2 = '0; st_value_in = '0; alu_res_mem = '0; result_wb = '0; dest_in = '0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases: ADD wrap, SUB with forwarding, shifts, MUL.
    applyStimulus(4'd0, 2'd0, 2'd0, 2'd0, 32'd7, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 5'd3, 3'b100);
    applyStimulus(4'd2, 2'd1, 2'd2, 2'd1, 32'd1, 32'd2, 32'd9, 32'd100, 32'd40, 5'd4, 3'b001);
    applyStimulus(4'd9, 2'd0, 2'd0, 2'd0, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 32'd0, 5'd5, 3'b100);
    applyStimulus(4'd10, 2'd3, 2'd3, 2'd3, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 32'd0, 5'd6, 3'b010);
    applyStimulus(4'd12, 2'd1, 2'd0, 2'd0, 32'd0, 32'h1_0001, 32'd77, 32'h1_0000, 32'd0, 5'd7, 3'b100);
    applyStimulus(4'd0, 2'd0, 2'd0, 2'd0, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0, 5'd8, 3'b100);
    idleCycles(3);

    // Reset partway through a MUL: nothing may come out of it.
    applyStimulus(4'd12, 2'd0, 2'd0, 2'd0, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 5'd9, 3'b100);
    idleCycles(5);
    @(negedge clk);
    rst = 1'b1;
    sbQ.delete();
    busyUntil = 0;
    #1;
    checkOutput("rstImmStall", 64'(stall), 64'd0);
    checkOutput("rstImmValid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd0, 2'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 5'd1, 3'b100);

    // Random traffic: any opcode, any select, occasional gaps.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] c;
      c = 4'($urandom);
      if ($urandom_range(0, 7) == 0) c = 4'd12;
      applyStimulus(c, 2'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                    $urandom, $urandom, 5'($urandom), 3'($urandom));
      if ($urandom_range(0, 5) == 0) idleCycles($urandom_range(1, 3));
    end

    idleCycles(1);
    for (int t = 0; t < 200 && sbQ.size() > 0; t++) idleCycles(1);
    if (sbQ.size() > 0) checkOutput("drainTimeout", 64'(sbQ.size()), 64'd0);
    idleCycles(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
